// File: rtl/dircc_types_pkg.sv
// Shared types and defaults for the DiRCC multicast send scheduler.
//   - DEF_* constants: default parameter values for the scheduler
//   - target_addr_t : multicast target address (thread hw address + device sw address)
//   - sched_state_e : scheduler FSM states
//   - idx_width()   : index width for n items, never less than one bit
package dircc_types_pkg;

  localparam int DEF_NUM_DEVICES   = 4;
  localparam int DEF_NUM_PORTS     = 8;
  localparam int DEF_MAX_TARGETS   = 16;
  localparam int DEF_HW_ADDR_WIDTH = 16;
  localparam int DEF_SW_ADDR_WIDTH = 8;
  localparam int DEF_LAMPORT_WIDTH = 32;

  typedef struct packed {
    logic [DEF_HW_ADDR_WIDTH-1:0] hw_addr;
    logic [DEF_SW_ADDR_WIDTH-1:0] sw_addr;
  } target_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EMIT,
    ST_COMMIT
  } sched_state_e;

  // A single device/port/target still needs a one-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Round-robin arbiter over a flat request vector.
//   req   : request flags, one per requester
//   ptr   : highest-priority index this cycle
//   grant : first set request at or above ptr, scanning circularly
//   any   : at least one request is set
module dircc_rr_arbiter
  import dircc_types_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [W:0]   sum;
  logic [W-1:0] cand;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    grant = '0;
    sum   = '0;
    cand  = '0;
    any   = |req;
    // Scan from the farthest offset down so the nearest request at or after ptr wins last.
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (W + 1)'(i);
      if (sum >= (W + 1)'(N)) sum = sum - (W + 1)'(N);
      cand = sum[W-1:0];
      if (req[cand]) grant = cand;
    end
  end

endmodule

// File: rtl/dircc_multicast_send_scheduler.sv
// Send / Lamport scheduler for a DiRCC processing element.
// Picks a ready-to-send (device, port) round-robin, reads its multicast target
// list from a synchronous table, emits one header per target over valid/ready,
// then pulses send_grant so the send handler can commit its state.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   hw_address               : this thread's hardware address
//   rts_ready                : request flags, bit d*NUM_PORTS+p
//   rx_done / rx_lamport     : received-packet pulse and its Lamport value
//   rx_busy                  : receive handler owns state, blocks new grants
//   tbl_dev/port/idx         : table lookup address
//   tbl_count / tbl_dest     : table read data, one cycle after the address
//   hdr_*                    : packet header stream to the sender
//   send_grant, grant_dev/port : commit pulse for the finished multicast
//   lamport                  : current Lamport clock
module dircc_multicast_send_scheduler
  import dircc_types_pkg::*;
#(
  parameter  int NUM_DEVICES   = DEF_NUM_DEVICES,
  parameter  int NUM_PORTS     = DEF_NUM_PORTS,
  parameter  int MAX_TARGETS   = DEF_MAX_TARGETS,
  parameter  int HW_ADDR_WIDTH = DEF_HW_ADDR_WIDTH,
  parameter  int SW_ADDR_WIDTH = DEF_SW_ADDR_WIDTH,
  parameter  int LAMPORT_WIDTH = DEF_LAMPORT_WIDTH,
  localparam int DEV_W  = idx_width(NUM_DEVICES),
  localparam int PORT_W = idx_width(NUM_PORTS),
  localparam int IDX_W  = idx_width(MAX_TARGETS),
  localparam int CNT_W  = $clog2(MAX_TARGETS + 1),
  localparam int DEST_W = HW_ADDR_WIDTH + SW_ADDR_WIDTH,
  localparam int NREQ   = NUM_DEVICES * NUM_PORTS,
  localparam int REQ_W  = idx_width(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [HW_ADDR_WIDTH-1:0] hw_address,
  input  logic [NREQ-1:0]          rts_ready,
  input  logic                     rx_done,
  input  logic [LAMPORT_WIDTH-1:0] rx_lamport,
  input  logic                     rx_busy,
  output logic [DEV_W-1:0]         tbl_dev,
  output logic [PORT_W-1:0]        tbl_port,
  output logic [IDX_W-1:0]         tbl_idx,
  input  logic [CNT_W-1:0]         tbl_count,
  input  logic [DEST_W-1:0]        tbl_dest,
  output logic                     hdr_valid,
  input  logic                     hdr_ready,
  output logic [DEST_W-1:0]        hdr_dest,
  output logic [SW_ADDR_WIDTH-1:0] hdr_src_dev,
  output logic [PORT_W-1:0]        hdr_src_port,
  output logic [LAMPORT_WIDTH-1:0] hdr_lamport,
  output logic                     hdr_last,
  output logic                     send_grant,
  output logic [DEV_W-1:0]         grant_dev,
  output logic [PORT_W-1:0]        grant_port,
  output logic [LAMPORT_WIDTH-1:0] lamport
);

  sched_state_e             state, state_nxt;
  logic [REQ_W-1:0]         ptr, win, g_flat;
  logic                     any_req, do_grant, gap, is_last, xfer;
  logic [DEV_W-1:0]         g_dev, win_dev;
  logic [PORT_W-1:0]        g_port, win_port;
  logic [IDX_W-1:0]         idx;
  logic [CNT_W-1:0]         count_q, count_clamped;
  logic [LAMPORT_WIDTH-1:0] lamport_q, stamp;

  // The thread address is not carried in the header today; kept for source addressing.
  logic unused_hw_address;
  assign unused_hw_address = ^hw_address;

  dircc_rr_arbiter #(.N(NREQ)) u_arb (
    .req   (rts_ready),
    .ptr   (ptr),
    .grant (win),
    .any   (any_req)
  );

  assign win_dev  = DEV_W'(int'(win) / NUM_PORTS);
  assign win_port = PORT_W'(int'(win) % NUM_PORTS);

  // A receive in the same cycle owns the Lamport clock, so the grant retries next cycle.
  assign do_grant = (state == ST_IDLE) && any_req && !rx_busy && !rx_done;

  assign count_clamped = (tbl_count > CNT_W'(MAX_TARGETS)) ? CNT_W'(MAX_TARGETS) : tbl_count;
  assign is_last       = (CNT_W'(idx) == count_q - CNT_W'(1));
  assign xfer          = hdr_valid && hdr_ready;

  // The table address is presented combinationally on the grant cycle so tbl_count
  // is already valid during LOOKUP.
  assign tbl_dev  = do_grant ? win_dev  : g_dev;
  assign tbl_port = do_grant ? win_port : g_port;
  assign tbl_idx  = do_grant ? '0       : idx;

  always_comb begin
    state_nxt  = state;
    hdr_valid  = 1'b0;
    send_grant = 1'b0;
    case (state)
      ST_IDLE:   if (do_grant) state_nxt = ST_LOOKUP;
      ST_LOOKUP: state_nxt = (count_clamped == '0) ? ST_COMMIT : ST_EMIT;
      ST_EMIT: begin
        // tbl_dest lags tbl_idx by a cycle, so valid is withheld right after idx advances.
        hdr_valid = !gap;
        if (hdr_valid && hdr_ready && is_last) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        send_grant = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign hdr_dest     = hdr_valid ? tbl_dest : '0;
  assign hdr_src_dev  = hdr_valid ? SW_ADDR_WIDTH'(g_dev) : '0;
  assign hdr_src_port = hdr_valid ? g_port : '0;
  assign hdr_lamport  = hdr_valid ? stamp : '0;
  assign hdr_last     = hdr_valid && is_last;
  assign grant_dev    = g_dev;
  assign grant_port   = g_port;
  assign lamport      = lamport_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      g_flat    <= '0;
      g_dev     <= '0;
      g_port    <= '0;
      idx       <= '0;
      count_q   <= '0;
      gap       <= 1'b0;
      lamport_q <= '0;
      stamp     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state <= state_nxt;
      gap   <= 1'b0;

      if (rx_done)
        lamport_q <= ((rx_lamport > lamport_q) ? rx_lamport : lamport_q) + LAMPORT_WIDTH'(1);
      else if (do_grant)
        lamport_q <= lamport_q + LAMPORT_WIDTH'(1);

      if (do_grant) begin
        g_flat <= win;
        g_dev  <= win_dev;
        g_port <= win_port;
        idx    <= '0;
        stamp  <= lamport_q + LAMPORT_WIDTH'(1);
      end

      if (state == ST_LOOKUP) count_q <= count_clamped;

      if (state == ST_EMIT && xfer && !is_last) begin
        idx <= idx + IDX_W'(1);
        gap <= 1'b1;
      end

      if (state == ST_COMMIT)
        ptr <= (g_flat == REQ_W'(NREQ - 1)) ? '0 : g_flat + REQ_W'(1);
    end
  end

endmodule

// File: tb/tb_dircc_multicast_send_scheduler.sv
// Self-checking bench for dircc_multicast_send_scheduler (2 devices x 2 ports,
// up to 4 targets). A synchronous table model feeds the DUT; a transaction-level
// reference (round-robin pointer, Lamport counter, expected header list) predicts
// every multicast.
module tb_dircc_multicast_send_scheduler;
  import dircc_types_pkg::*;

  localparam int ND = 2;
  localparam int NP = 2;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] hw_address = 16'h1234;
  logic [3:0]  rts_ready = '0;
  logic        rx_done = 1'b0;
  logic [31:0] rx_lamport = '0;
  logic        rx_busy = 1'b0;
  logic [0:0]  tbl_dev, tbl_port;
  logic [1:0]  tbl_idx;
  logic [2:0]  tbl_count;
  logic [23:0] tbl_dest;
  logic        hdr_valid, hdr_ready = 1'b0, hdr_last, send_grant;
  logic [23:0] hdr_dest;
  logic [7:0]  hdr_src_dev;
  logic [0:0]  hdr_src_port, grant_dev, grant_port;
  logic [31:0] hdr_lamport, lamport;

  dircc_multicast_send_scheduler #(
    .NUM_DEVICES(ND), .NUM_PORTS(NP), .MAX_TARGETS(MT),
    .HW_ADDR_WIDTH(16), .SW_ADDR_WIDTH(8), .LAMPORT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .hw_address(hw_address), .rts_ready(rts_ready),
    .rx_done(rx_done), .rx_lamport(rx_lamport), .rx_busy(rx_busy),
    .tbl_dev(tbl_dev), .tbl_port(tbl_port), .tbl_idx(tbl_idx),
    .tbl_count(tbl_count), .tbl_dest(tbl_dest),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dest(hdr_dest),
    .hdr_src_dev(hdr_src_dev), .hdr_src_port(hdr_src_port),
    .hdr_lamport(hdr_lamport), .hdr_last(hdr_last),
    .send_grant(send_grant), .grant_dev(grant_dev), .grant_port(grant_port),
    .lamport(lamport)
  );

  always #5 clk = ~clk;

  // Synchronous multicast table: read data appears one cycle after the address.
  logic [2:0]   cnt_mem  [ND][NP];
  target_addr_t dest_mem [ND][NP][MT];
  always @(posedge clk) begin
    tbl_count <= cnt_mem[tbl_dev][tbl_port];
    tbl_dest  <= dest_mem[tbl_dev][tbl_port][tbl_idx];
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_ptr = 0;
  logic [31:0] m_lamport = '0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] req);
    for (int k = 0; k < ND * NP; k++)
      if (req[(m_ptr + k) % (ND * NP)]) return (m_ptr + k) % (ND * NP);
    return 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; rts_ready = '0; rx_done = 1'b0; rx_busy = 1'b0; hdr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_ptr = 0;
    m_lamport = '0;
  endtask

  task automatic randomize_table(input int max_cnt);
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NP; p++) begin
        cnt_mem[d][p] = 3'($urandom_range(0, max_cnt));
        for (int t = 0; t < MT; t++) begin
          dest_mem[d][p][t].hw_addr = 16'($urandom);
          dest_mem[d][p][t].sw_addr = 8'($urandom);
        end
      end
  endtask

  // One multicast, starting at posedge+1 with the DUT idle. Cycle 0 is the grant cycle.
  task automatic send(input logic [3:0] req, input bit hold, input int stall,
                      input bit rnd_ready, input int rx_cyc, input logic [31:0] rx_val);
    int flat, d, p, n, nh, commit_cyc;
    logic [31:0] stamp;
    bit done, pend;
    flat = model_winner(req);
    d = flat / NP;
    p = flat % NP;
    n = (cnt_mem[d][p] > 3'(MT)) ? MT : int'(cnt_mem[d][p]);
    nh = 0; done = 0; pend = 0; commit_cyc = -1; stamp = '0;
    rts_ready = req;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      hdr_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : (cyc > stall + 1);
      rx_done    = (cyc == rx_cyc);
      rx_lamport = rx_done ? rx_val : $urandom;
      @(negedge clk);
      if (cyc == 0) begin
        check("lamport_before_grant", lamport, m_lamport);
        m_lamport = m_lamport + 1;
        stamp = m_lamport;
      end
      if (pend) check("valid_held_under_stall", hdr_valid, 1);
      pend = hdr_valid && !hdr_ready;
      if (hdr_valid) begin
        if (nh < n) begin
          check("hdr_dest", hdr_dest, dest_mem[d][p][nh]);
          check("hdr_lamport", hdr_lamport, stamp);
          check("hdr_last", hdr_last, (nh == n - 1));
          check("hdr_src_dev", hdr_src_dev, d);
          check("hdr_src_port", hdr_src_port, p);
          if (hdr_ready) nh++;
        end else begin
          check("hdr_extra", hdr_valid, 0);
        end
      end
      if (send_grant) begin
        done = 1;
        commit_cyc = cyc;
        check("grant_dev", grant_dev, d);
        check("grant_port", grant_port, p);
      end
      if (rx_done) m_lamport = ((rx_val > m_lamport) ? rx_val : m_lamport) + 1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      if (!hold) rts_ready = '0;
    end
    check("send_grant_seen", done, 1);
    check("hdr_count", nh, n);
    if (!rnd_ready && stall == 0)
      check("commit_cycle", commit_cyc, (n == 0) ? 2 : 2 * n + 1);
    check("lamport_after", lamport, m_lamport);
    m_ptr = (flat + 1) % (ND * NP);
  endtask

  initial begin
    bit seen;
    randomize_table(3);

    // Reset state
    @(negedge clk);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_send_grant", send_grant, 0);
    check("rst_grant_dev", grant_dev, 0);
    check("rst_grant_port", grant_port, 0);
    check("rst_lamport", lamport, 0);
    check("rst_tbl_idx", tbl_idx, 0);
    check("rst_hdr_dest", hdr_dest, 0);
    do_reset();

    // Single device 1 / port 0, three targets
    cnt_mem[1][0] = 3'd3;
    send(4'b0100, 0, 0, 0, -1, '0);
    check("t1_lamport_is_1", lamport, 32'd1);

    // Round-robin order with all requests held, then wrap to (0,0)
    do_reset();
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NP; p++) cnt_mem[d][p] = 3'd1;
    for (int k = 0; k < 4; k++) send(4'b1111, 1, 0, 0, -1, '0);
    send(4'b1111, 0, 0, 0, -1, '0);
    check("rr_ptr_wrapped_to_1", m_ptr, 1);

    // Receive in the same cycle as a pending request takes priority
    do_reset();
    rx_done = 1'b1; rx_lamport = 32'd4;
    @(posedge clk); #1;
    rx_done = 1'b0;
    m_lamport = 32'd5;
    rts_ready = 4'b0100; rx_done = 1'b1; rx_lamport = 32'd20;
    @(negedge clk);
    check("rx_prio_no_hdr", hdr_valid, 0);
    @(posedge clk); #1;
    rx_done = 1'b0;
    m_lamport = 32'd21;
    send(4'b0100, 0, 0, 0, -1, '0);
    check("rx_prio_lamport_22", lamport, 32'd22);

    // Back-pressure for >10 cycles with a receive during EMIT
    cnt_mem[1][1] = 3'd3;
    send(4'b1000, 0, 11, 0, 5, 32'd100);
    check("stall_lamport_101", lamport, 32'd101);

    // Zero targets, then rx_busy blocking grants
    cnt_mem[0][1] = 3'd0;
    send(4'b0010, 0, 0, 0, -1, '0);
    rx_busy = 1'b1; rts_ready = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("busy_no_grant_lamport", lamport, m_lamport);
      check("busy_no_send_grant", send_grant, 0);
      @(posedge clk); #1;
    end
    rx_busy = 1'b0;
    cnt_mem[0][0] = 3'd2;
    send(4'b0001, 0, 0, 0, -1, '0);

    // Lamport wrap: stamp becomes 0
    rx_done = 1'b1; rx_lamport = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    rx_done = 1'b0;
    m_lamport = 32'hFFFF_FFFF;
    send(4'b0100, 0, 0, 0, -1, '0);
    check("wrap_lamport_0", lamport, 32'd0);

    // Counts above MAX_TARGETS are clamped
    cnt_mem[1][1] = 3'd7;
    send(4'b1000, 0, 0, 0, -1, '0);

    // Reset in the middle of EMIT abandons the multicast
    cnt_mem[0][0] = 3'd4;
    rts_ready = 4'b0001; hdr_ready = 1'b1; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = hdr_valid;
      @(posedge clk); #1;
      rts_ready = '0;
    end
    check("emit_reached", seen, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_hdr_valid", hdr_valid, 0);
    check("mid_rst_hdr_dest", hdr_dest, 0);
    check("mid_rst_hdr_lamport", hdr_lamport, 0);
    check("mid_rst_hdr_last", hdr_last, 0);
    check("mid_rst_send_grant", send_grant, 0);
    check("mid_rst_grant_dev", grant_dev, 0);
    check("mid_rst_lamport", lamport, 0);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post_rst_no_send_grant", send_grant, 0);
      check("post_rst_no_hdr", hdr_valid, 0);
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model
    for (int it = 0; it < 30; it++) begin
      logic [3:0] req;
      int rxc;
      randomize_table(7);
      req = 4'($urandom_range(1, 15));
      rxc = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 8));
      send(req, 0, 0, 1'($urandom_range(0, 1)), rxc, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dircc_multicast_send_scheduler.md
Name: dircc_multicast_send_scheduler

Overview:
- Next-generation send/lamport scheduler for a DiRCC processing element.
- Supports NUM_DEVICES devices per thread, each with NUM_PORTS output ports.
- Arbitrates ready-to-send requests round-robin, looks up multicast target lists from a synchronous table, and emits one packet header per target over a valid/ready handshake.
- Owns the thread's Lamport clock; sits between the rts handlers and the Avalon-ST packet sender.

Parameters:
- NUM_DEVICES, 4, devices hosted by this thread (>=1)
- NUM_PORTS, 8, output ports per device (>=1)
- MAX_TARGETS, 16, max multicast fan-out per port (>=1)
- HW_ADDR_WIDTH, 16, hardware (thread) address width
- SW_ADDR_WIDTH, 8, device address width within a thread
- LAMPORT_WIDTH, 32, Lamport counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- hw_address  in  HW_ADDR_WIDTH  this thread's hardware address
- rts_ready  in  NUM_DEVICES*NUM_PORTS  request flags; bit d*NUM_PORTS+p = device d, port p
- rx_done  in  1  single-cycle pulse: packet received
- rx_lamport  in  LAMPORT_WIDTH  Lamport value of received packet; valid with rx_done
- rx_busy  in  1  receive handler owns state; inhibits new grants
- tbl_dev  out  clog2(NUM_DEVICES)  table lookup device index
- tbl_port  out  clog2(NUM_PORTS)  table lookup port index
- tbl_idx  out  clog2(MAX_TARGETS)  table lookup target index
- tbl_count  in  clog2(MAX_TARGETS+1)  target count; 1 cycle after tbl_dev/tbl_port
- tbl_dest  in  HW_ADDR_WIDTH+SW_ADDR_WIDTH  target address; 1 cycle after tbl_idx
- hdr_valid  out  1  header valid
- hdr_ready  in  1  sender accepts header
- hdr_dest  out  HW_ADDR_WIDTH+SW_ADDR_WIDTH  destination address
- hdr_src_dev  out  SW_ADDR_WIDTH  source device
- hdr_src_port  out  clog2(NUM_PORTS)  source port
- hdr_lamport  out  LAMPORT_WIDTH  Lamport stamp
- hdr_last  out  1  last copy of this multicast
- send_grant  out  1  pulse: send handler commits state for grant_dev/grant_port
- grant_dev  out  clog2(NUM_DEVICES)  granted device
- grant_port  out  clog2(NUM_PORTS)  granted port
- lamport  out  LAMPORT_WIDTH  current Lamport value

Behaviour:
- Reset: all outputs 0, FSM IDLE, round-robin pointer 0, lamport 0.
- Lamport update on rx_done, in any state: lamport <= max(lamport, rx_lamport)+1, modulo 2^LAMPORT_WIDTH. Wrap-around is silent.
- FSM states: IDLE, LOOKUP, EMIT, COMMIT.
- IDLE:
  - Grants when rts_ready != 0, rx_busy = 0, and rx_done = 0 in that cycle. A receive has priority; retry the next cycle.
  - Winner: first set bit at or above the pointer, circular over the flattened index.
  - On grant: latch dev/port, drive tbl_dev/tbl_port, tbl_idx=0, go to LOOKUP.
  - On grant, lamport <= lamport+1 and the stamp latches that new value.
- LOOKUP (1 cycle): latch tbl_count.
  - Count 0: go to COMMIT, no header emitted.
  - Otherwise: go to EMIT.
- EMIT:
  - hdr_valid=1 with tbl_dest for the current idx; hdr_lamport is the latched stamp for every copy.
  - hdr_src_dev = zero-extended grant_dev. hdr_last=1 when idx == count-1.
  - Transfer occurs when hdr_valid && hdr_ready.
  - After a non-last transfer: idx+1, hdr_valid drops one cycle while the table read repeats. One header per 2 cycles is the max rate.
  - After the last transfer: go to COMMIT.
  - Header outputs stay stable while hdr_valid && !hdr_ready.
- COMMIT (1 cycle): send_grant=1 with grant_dev/grant_port. Pointer <= winner+1 (wraps to 0). Go to IDLE.
- Counts above MAX_TARGETS are clamped to MAX_TARGETS.
- rx_done during EMIT updates lamport but not the latched stamp. A later grant gets the incremented value.
- rts_ready deasserting mid-multicast does not abort the multicast.
- Asynchronous reset mid-multicast abandons the remaining copies; no send_grant is issued.

Decomposition:
- Shared package dircc_types_pkg:
  - typedef for the target address struct (hw_addr, sw_addr)
  - the scheduler state enum
  - the default parameter constants
- One sub-module, dircc_rr_arbiter: parameterised width N, inputs req and pointer, outputs grant index and any.

Test Plan:
- Reset, then NUM_DEVICES=2, NUM_PORTS=2, rts_ready=4'b0100, tbl_count=3, hdr_ready=1 -> three headers, dests from table idx 0,1,2; all hdr_lamport=1; hdr_last only on the third; then send_grant with dev=1, port=0; lamport=1.
- rts_ready=4'b1111 held through four grants -> grant order (dev,port) = (0,0),(0,1),(1,0),(1,1); pointer wraps back to (0,0).
- lamport=5, rx_done with rx_lamport=20 in the same cycle as a pending request -> lamport=21, no grant that cycle; next grant stamps 22.
- hdr_ready held low 10 cycles during EMIT -> hdr_dest/hdr_lamport/hdr_last stable, hdr_valid stays 1; rx_done with rx_lamport=100 meanwhile -> stamp unchanged, lamport=101.
- tbl_count=0 -> no hdr_valid, send_grant 2 cycles after the grant; rx_busy=1 with rts_ready set -> no grant until rx_busy clears.
- lamport forced to 0xFFFFFFFF, grant -> stamp 0; reset asserted mid-EMIT -> all outputs 0 immediately, no send_grant.
